// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - ROWSxCOLS matrix keypad scanner with debounce and event slot; optional auto-repeat under KEYPAD_REPEAT_EN
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int REPEAT_DELAY    = 5000,
    parameter int REPEAT_PERIOD   = 1000,
    localparam int ID_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] rows_in,
    output logic [COLS-1:0] cols_out,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [ID_W-1:0] key_id,
    output logic            key_repeat,
    output logic            key_down,
    output logic            overrun,
    input  logic            overrun_clr
);

    localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_MAX     = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int DEB_LAST    = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    logic [ROWS-1:0]  row_meta_q, row_sync_q;
    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d, col_next;
    logic [RW-1:0]    row_q, row_d, row_low;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COLS-1:0]  cols_out_q, cols_out_d;
    logic             key_valid_q, key_valid_d;
    logic [ID_W-1:0]  key_id_q, key_id_d, ev_id;
    logic             key_repeat_q, key_repeat_d;
    logic             key_down_q, key_down_d;
    logic             overrun_q, overrun_d;
    logic             row_any, row_bit, ev_fire, ev_repeat;

`ifdef KEYPAD_REPEAT_EN
    localparam int RP_MAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W        = $clog2(RP_MAX + 1);
    localparam int DELAY_LAST  = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
    localparam int PERIOD_LAST = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d, rep_tgt;
    logic            rep_first_q, rep_first_d;
`endif

    // Scan/debounce/held state machine plus the event slot and overrun flag
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        key_down_d = key_down_q;
        ev_fire    = 1'b0;
        ev_repeat  = 1'b0;
        row_any    = 1'b0;
        row_low    = '0;

        // Lowest-index low row wins when several keys share the driven column
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_sync_q[r]) begin
                row_any = 1'b1;
                row_low = RW'(r);
            end
        end

        col_next = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
        row_bit  = row_sync_q[row_q];
        ev_id    = ID_W'(32'(row_q) * COLS + 32'(col_q));

        case (state_q)
            ST_SCAN: begin
                if (cnt_q >= CNT_W'(SETTLE_LAST)) begin
                    cnt_d = '0;
                    if (row_any) begin
                        row_d   = row_low;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (row_bit) begin
                    state_d = ST_SCAN;
                    col_d   = col_next;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(DEB_LAST)) begin
                    ev_fire    = 1'b1;
                    key_down_d = 1'b1;
                    state_d    = ST_HELD;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                // Counter tracks consecutive released samples; any press sample restarts it
                if (row_bit) begin
                    if (cnt_q >= CNT_W'(DEB_LAST)) begin
                        key_down_d = 1'b0;
                        state_d    = ST_SCAN;
                        col_d      = col_next;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_SCAN;
                col_d   = '0;
                cnt_d   = '0;
            end
        endcase

`ifdef KEYPAD_REPEAT_EN
        // Repeat timer runs only while held; first interval is the delay, then the period
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
        rep_tgt     = rep_first_q ? RP_W'(DELAY_LAST) : RP_W'(PERIOD_LAST);
        if (state_q == ST_HELD) begin
            rep_first_d = rep_first_q;
            rep_cnt_d   = (rep_cnt_q >= rep_tgt) ? rep_cnt_q : rep_cnt_q + 1'b1;
            // A released sample means release debounce is in progress: hold off repeats
            if (!row_bit && rep_cnt_q >= rep_tgt) begin
                ev_fire     = 1'b1;
                ev_repeat   = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end
        end
`endif

        cols_out_d   = ~(COLS'(1) << col_d);
        key_valid_d  = key_valid_q;
        key_id_d     = key_id_q;
        key_repeat_d = key_repeat_q;
        overrun_d    = overrun_q & ~overrun_clr;

        if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
        // A new event may refill the slot in the same cycle it is being drained
        if (ev_fire) begin
            if (!key_valid_q || key_ready) begin
                key_valid_d  = 1'b1;
                key_id_d     = ev_id;
                key_repeat_d = ev_repeat;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // All state, the row synchroniser and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q   <= '1;
            row_sync_q   <= '1;
            state_q      <= ST_SCAN;
            col_q        <= '0;
            row_q        <= '0;
            cnt_q        <= '0;
            cols_out_q   <= '1;
            key_valid_q  <= 1'b0;
            key_id_q     <= '0;
            key_repeat_q <= 1'b0;
            key_down_q   <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q    <= '0;
            rep_first_q  <= 1'b1;
`endif
        end else begin
            row_meta_q   <= rows_in;
            row_sync_q   <= row_meta_q;
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            cols_out_q   <= cols_out_d;
            key_valid_q  <= key_valid_d;
            key_id_q     <= key_id_d;
            key_repeat_q <= key_repeat_d;
            key_down_q   <= key_down_d;
            overrun_q    <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q    <= rep_cnt_d;
            rep_first_q  <= rep_first_d;
`endif
        end
    end

    assign cols_out   = cols_out_q;
    assign key_valid  = key_valid_q;
    assign key_id     = key_id_q;
    assign key_repeat = key_repeat_q;
    assign key_down   = key_down_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a 4x4 keypad model
module tb_keypad_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows_in;
    logic [3:0]  cols_out;
    logic        key_valid;
    logic        key_ready;
    logic [3:0]  key_id;
    logic        key_repeat;
    logic        key_down;
    logic        overrun;
    logic        overrun_clr;
    logic [15:0] keys;

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(200),
        .REPEAT_DELAY(5000), .REPEAT_PERIOD(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rows_in(rows_in), .cols_out(cols_out),
        .key_valid(key_valid), .key_ready(key_ready), .key_id(key_id),
        .key_repeat(key_repeat), .key_down(key_down), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    // Keypad model: a pressed key pulls its row low while its column is driven low
    always_comb begin
        rows_in = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys[r*COLS+c] && !cols_out[c]) rows_in[r] = 1'b0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every accepted event
    int obs_n = 0;
    int obs_id[512];
    int obs_rep[512];
    int obs_cyc[512];
    always @(negedge clk) begin
        if (rst_n && key_valid && key_ready) begin
            if (obs_n < 512) begin
                obs_id[obs_n]  = int'(key_id);
                obs_rep[obs_n] = int'(key_repeat);
                obs_cyc[obs_n] = cyc;
            end
            obs_n = obs_n + 1;
        end
    end

    typedef struct { int id; int rep; } exp_t;
    exp_t exp_q[$];
    int   rd = 0;

    typedef struct { logic [15:0] keys; int id; } vec_t;
    vec_t vecs[7];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_obs(input int target, input int budget, input string name);
        int k = 0;
        while (obs_n < target && k < budget) begin
            tick();
            k++;
        end
        chk(name, int'(obs_n >= target), 1);
    endtask

    task automatic wait_down(input logic val, input int budget, input string name);
        int k = 0;
        while (key_down !== val && k < budget) begin
            tick();
            k++;
        end
        chk(name, int'(key_down), int'(val));
    endtask

    task automatic drain();
        exp_t e;
        while (rd < obs_n) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got id %0d rep %0d, expected none", obs_id[rd], obs_rep[rd]);
            end else begin
                e = exp_q.pop_front();
                chk("event_id", obs_id[rd], e.id);
                chk("event_repeat", obs_rep[rd], e.rep);
            end
            rd++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, base, lat;
        vecs[0] = '{16'h0200, 9};
        vecs[1] = '{16'h0001, 0};
        vecs[2] = '{16'h8000, 15};
        vecs[3] = '{16'h1010, 4};
        vecs[4] = '{16'h0008, 3};
        vecs[5] = '{16'h0400, 10};
        vecs[6] = '{16'h4040, 6};

        keys = '0; key_ready = 1'b1; overrun_clr = 1'b0; rst_n = 1'b0;
        tick(3);
        chk("reset_cols", int'(cols_out), 15);
        chk("reset_valid", int'(key_valid), 0);
        chk("reset_id", int'(key_id), 0);
        chk("reset_repeat", int'(key_repeat), 0);
        chk("reset_down", int'(key_down), 0);
        chk("reset_overrun", int'(overrun), 0);

        rst_n = 1'b1;
        tick(10);
        chk("scan_onehot", $countones(~cols_out), 1);
        rst_n = 1'b0;
        #1;
        chk("midscan_reset_cols", int'(cols_out), 15);
        chk("midscan_reset_valid", int'(key_valid), 0);
        chk("midscan_reset_overrun", int'(overrun), 0);
        tick(2);
        rst_n = 1'b1;
        tick(5);

        // Single presses, lowest-row priority, release debounce
        for (int i = 0; i < 7; i++) begin
            base  = obs_n;
            start = cyc;
            keys  = vecs[i].keys;
            exp_q.push_back('{vecs[i].id, 0});
            wait_obs(base + 1, 400, "press_event");
            lat = obs_cyc[base] - start;
            chk("press_latency_window", int'(lat >= 200 && lat <= 240), 1);
            drain();
            tick(3);
            chk("held_down", int'(key_down), 1);
            keys = '0;
            tick(100);
            chk("release_debouncing_down", int'(key_down), 1);
            wait_down(1'b0, 300, "release_down");
            tick(20);
            drain();
            chk("one_event_per_press", obs_n, base + 1);
        end

        // Bouncing contact: 12 segments of 50 clocks, then stable
        base = obs_n;
        exp_q.push_back('{9, 0});
        for (int s = 0; s < 12; s++) begin
            keys = (s % 2 == 0) ? 16'h0200 : 16'h0000;
            tick(50);
        end
        chk("bounce_no_event", obs_n, base);
        keys = 16'h0200;
        wait_obs(base + 1, 400, "bounce_event");
        keys = '0;
        wait_down(1'b0, 300, "bounce_release");
        tick(20);
        drain();
        chk("bounce_single_event", obs_n, base + 1);

        // Full slot: second press is dropped and flags overrun
        key_ready = 1'b0;
        exp_q.push_back('{5, 0});
        keys = 16'h0020;
        begin
            int k = 0;
            while (!key_valid && k < 400) begin tick(); k++; end
        end
        chk("ovr_first_valid", int'(key_valid), 1);
        keys = '0;
        wait_down(1'b0, 300, "ovr_release1");
        keys = 16'h0040;
        wait_down(1'b1, 400, "ovr_press2");
        tick(2);
        chk("ovr_valid_held", int'(key_valid), 1);
        chk("ovr_id_held", int'(key_id), 5);
        chk("ovr_flag", int'(overrun), 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);
        key_ready = 1'b1;
        tick(2);
        drain();
        chk("ovr_slot_empty", int'(key_valid), 0);
        keys = '0;
        wait_down(1'b0, 300, "ovr_release2");
        tick(20);
        drain();

        // Long hold of id 0: repeats only when the repeat feature is built in
        base = obs_n;
        exp_q.push_back('{0, 0});
`ifdef KEYPAD_REPEAT_EN
        exp_q.push_back('{0, 1});
        exp_q.push_back('{0, 1});
        exp_q.push_back('{0, 1});
`endif
        keys = 16'h0001;
        wait_obs(base + 1, 400, "hold_first_event");
        tick(7500);
        keys = '0;
        wait_down(1'b0, 300, "hold_release");
        tick(20);
`ifdef KEYPAD_REPEAT_EN
        chk("repeat_count", obs_n - base, 4);
        if (obs_n >= base + 4) begin
            chk("repeat_delay", obs_cyc[base+1] - obs_cyc[base], 5000);
            chk("repeat_period1", obs_cyc[base+2] - obs_cyc[base+1], 1000);
            chk("repeat_period2", obs_cyc[base+3] - obs_cyc[base+2], 1000);
        end
`else
        chk("no_repeat_count", obs_n - base, 1);
`endif
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
